// File: rtl/execute_pipe.sv
// Execute stage: ALU (ADD/SUB/AND/ORR/PASSB), iterative shift-add MUL, branch-target adder.
// Latency: 1 edge for single-cycle ops, WORD+1 edges for MUL.
// Backpressure: one result register; in_ready follows out_ready when full, 0 while multiplying.
module execute_pipe #(
    parameter int WORD     = 64,
    parameter int BR_SHIFT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] cur_pc,
    input  logic [WORD-1:0] read_data1,
    input  logic [WORD-1:0] read_data2,
    input  logic [WORD-1:0] sign_extended_output,
    input  logic [1:0]      alu_op,
    input  logic [10:0]     opcode,
    input  logic            alu_src,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] branch_target,
    output logic [WORD-1:0] alu_result,
    output logic            zero,
    output logic            busy
);

    localparam int CNT_W = $clog2(WORD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD);

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FULL} state_t;
    typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_PASSB, FN_MUL} alu_fn_t;

    typedef struct packed {
        logic [WORD-1:0] mcand;
        logic [WORD-1:0] mplier;
        logic [WORD-1:0] prod;
    } mul_t;

    state_t          state_q, state_d;
    alu_fn_t         fn;
    mul_t            mul_q;
    logic [CNT_W-1:0] mul_cnt;
    logic [WORD-1:0] b_sel;
    logic [WORD-1:0] res;
    logic [WORD-1:0] imm_shifted;
    logic [WORD-1:0] bt_next;
    logic            accept;

    always_comb begin
        fn = FN_ADD;
        case (alu_op)
            2'b01: fn = FN_PASSB;
            2'b10: begin
                case (opcode)
                    OPC_ADD: fn = FN_ADD;
                    OPC_SUB: fn = FN_SUB;
                    OPC_AND: fn = FN_AND;
                    OPC_ORR: fn = FN_ORR;
                    OPC_MUL: fn = FN_MUL;
                    default: fn = FN_ADD;
                endcase
            end
            default: fn = FN_ADD;
        endcase
    end

    always_comb begin
        b_sel       = alu_src ? sign_extended_output : read_data2;
        imm_shifted = sign_extended_output << BR_SHIFT;
        bt_next     = cur_pc + imm_shifted;
        res         = '0;
        case (fn)
            FN_ADD:   res = read_data1 + b_sel;
            FN_SUB:   res = read_data1 - b_sel;
            FN_AND:   res = read_data1 & b_sel;
            FN_ORR:   res = read_data1 | b_sel;
            FN_PASSB: res = b_sel;
            default:  res = '0;
        endcase
    end

    // Reset forces in_ready low so nothing is taken while the block is being cleared.
    assign in_ready  = !reset && ((state_q == ST_IDLE) || (state_q == ST_FULL && out_ready));
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == ST_FULL);
    assign busy      = (state_q == ST_MUL) && (mul_cnt != CNT_LAST);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = (fn == FN_MUL) ? ST_MUL : ST_FULL;
                end
                ST_MUL: begin
                    if (mul_cnt == CNT_LAST) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (accept)         state_d = (fn == FN_MUL) ? ST_MUL : ST_FULL;
                    else if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // After WORD iterations the extra MUL cycle (count == WORD) publishes the product.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result    <= '0;
            branch_target <= '0;
            zero          <= 1'b1;
            mul_q         <= '0;
            mul_cnt       <= '0;
        end else if (accept) begin
            branch_target <= bt_next;
            if (fn == FN_MUL) begin
                mul_q.mcand  <= read_data1;
                mul_q.mplier <= b_sel;
                mul_q.prod   <= '0;
                mul_cnt      <= '0;
            end else begin
                alu_result <= res;
                zero       <= (res == '0);
            end
        end else if (!flush && state_q == ST_MUL) begin
            if (mul_cnt != CNT_LAST) begin
                if (mul_q.mplier[0]) mul_q.prod <= mul_q.prod + mul_q.mcand;
                mul_q.mcand  <= mul_q.mcand << 1;
                mul_q.mplier <= mul_q.mplier >> 1;
                mul_cnt      <= mul_cnt + 1'b1;
            end else begin
                alu_result <= mul_q.prod;
                zero       <= (mul_q.prod == '0);
            end
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed scenarios followed by a randomized scoreboard phase.
module tb_execute_pipe;

    localparam int W = 16;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] bt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, alu_src, flush, out_valid, out_ready, zero, busy;
    logic [W-1:0] cur_pc, read_data1, read_data2, sign_extended_output, branch_target, alu_result;
    logic [1:0]   alu_op;
    logic [10:0]  opcode;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    execute_pipe #(.WORD(W), .BR_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cur_pc(cur_pc), .read_data1(read_data1), .read_data2(read_data2),
        .sign_extended_output(sign_extended_output), .alu_op(alu_op), .opcode(opcode),
        .alu_src(alu_src), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .branch_target(branch_target), .alu_result(alu_result), .zero(zero), .busy(busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [10:0] opc, input logic src,
                          input logic [W-1:0] pc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] im);
        alu_op = aop; opcode = opc; alu_src = src; cur_pc = pc;
        read_data1 = a; read_data2 = b; sign_extended_output = im;
    endtask

    function automatic logic [10:0] rand_opc();
        logic [10:0] o;
        case ($urandom_range(0, 4))
            0: o = OPC_ADD;
            1: o = OPC_SUB;
            2: o = OPC_AND;
            3: o = OPC_ORR;
            default: begin
                o = 11'($urandom);
                if (o == OPC_MUL) o = o ^ 11'd1;
            end
        endcase
        return o;
    endfunction

    task automatic rand_op(input bit want_mul);
        if (want_mul) set_op(2'b10, OPC_MUL, 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        else          set_op(2'($urandom), rand_opc(), 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Reference: the architectural meaning of each operation, computed with plain integer arithmetic.
    function automatic exp_t model_now();
        exp_t        m;
        logic [W-1:0] b;
        int unsigned p;
        b = alu_src ? sign_extended_output : read_data2;
        m.r = read_data1 + b;
        if (alu_op == 2'b01) m.r = b;
        else if (alu_op == 2'b10) begin
            if (opcode == OPC_SUB)      m.r = read_data1 - b;
            else if (opcode == OPC_AND) m.r = read_data1 & b;
            else if (opcode == OPC_ORR) m.r = read_data1 | b;
            else if (opcode == OPC_MUL) begin
                p   = 32'(read_data1) * 32'(b);
                m.r = W'(p % 65536);
            end
        end
        p    = 32'(cur_pc) + 32'(sign_extended_output) * 4;
        m.bt = W'(p % 65536);
        return m;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int spur;
        reset = 1; in_valid = 0; flush = 0; out_ready = 1;
        set_op(2'b00, 11'd0, 1'b0, '0, '0, '0, '0);
        tick; tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_result", alu_result, 0);
        chk("rst_branch_target", branch_target, 0);
        chk("rst_zero", zero, 1);
        reset = 0; #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ADD with branch target
        set_op(2'b10, OPC_ADD, 1'b0, 16'h0100, 16'd5, 16'd7, 16'd3);
        in_valid = 1; tick; in_valid = 0;
        chk("add_valid", out_valid, 1);
        chk("add_result", alu_result, 16'd12);
        chk("add_zero", zero, 0);
        chk("add_bt", branch_target, 16'h010C);
        tick;
        chk("add_released", out_valid, 0);

        // SUB to zero held under stall; inputs change after acceptance
        out_ready = 0;
        set_op(2'b10, OPC_SUB, 1'b0, 16'h0, 16'h55, 16'h55, 16'h0);
        in_valid = 1; tick; in_valid = 0;
        read_data1 = 16'h1234; read_data2 = 16'h4321; #1;
        for (int i = 0; i < 3; i++) begin
            chk("sub_hold_valid", out_valid, 1);
            chk("sub_hold_result", alu_result, 0);
            chk("sub_hold_zero", zero, 1);
            chk("sub_hold_in_ready", in_ready, 0);
            tick;
        end
        out_ready = 1; #1;
        chk("sub_release_in_ready", in_ready, 1);
        tick;
        chk("sub_released", out_valid, 0);

        // MUL wrapping to 16 bits
        set_op(2'b10, OPC_MUL, 1'b0, 16'h0, 16'h0100, 16'h0101, 16'h0);
        in_valid = 1; tick; in_valid = 0;
        read_data1 = 16'hFFFF; read_data2 = 16'hFFFF;
        for (int k = 0; k <= W; k++) begin
            chk("mul_busy", busy, (k < W) ? 16'd1 : 16'd0);
            chk("mul_no_valid", out_valid, 0);
            chk("mul_in_ready", in_ready, 0);
            tick;
        end
        chk("mul_valid", out_valid, 1);
        chk("mul_result", alu_result, 16'h0100);
        chk("mul_busy_done", busy, 0);
        tick;

        // Eight back-to-back single-cycle ops, the fourth is PASSB of zero
        for (int i = 0; i < 8; i++) begin
            if (i == 3) set_op(2'b01, 11'($urandom), 1'b0, W'($urandom), W'($urandom), 16'h0, W'($urandom));
            else        rand_op(1'b0);
            e = model_now();
            in_valid = 1; tick;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", alu_result, e.r);
            chk("b2b_zero", zero, (e.r == 0) ? 16'd1 : 16'd0);
            chk("b2b_bt", branch_target, e.bt);
        end
        in_valid = 0; tick;
        chk("b2b_drained", out_valid, 0);

        // Flush on MUL cycle 5 together with an offered ADD
        rand_op(1'b1);
        in_valid = 1; tick; in_valid = 0;
        repeat (4) tick;
        chk("flush_pre_busy", busy, 1);
        flush = 1;
        set_op(2'b10, OPC_ADD, 1'b0, 16'h0, 16'd1, 16'd2, 16'd0);
        in_valid = 1; tick; flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_idle_in_ready", in_ready, 1);
        spur = 0;
        repeat (W + 4) begin
            if (out_valid) spur++;
            tick;
        end
        chk("flush_no_output", 16'(spur), 0);
        rand_op(1'b0);
        e = model_now();
        in_valid = 1; tick; in_valid = 0;
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_result", alu_result, e.r);

        // Flush while FULL and stalled, then flush in IDLE
        out_ready = 0; flush = 1; tick; flush = 0; out_ready = 1;
        chk("flush_full_out_valid", out_valid, 0);
        flush = 1; tick; flush = 0;
        chk("flush_idle_out_valid", out_valid, 0);
        chk("flush_idle_in_ready", in_ready, 1);

        // Reset in the middle of a multiply
        rand_op(1'b1);
        in_valid = 1; tick; in_valid = 0;
        repeat (6) tick;
        reset = 1; #1;
        chk("rmul_in_ready", in_ready, 0);
        tick;
        chk("rmul_out_valid", out_valid, 0);
        chk("rmul_busy", busy, 0);
        chk("rmul_alu_result", alu_result, 0);
        chk("rmul_bt", branch_target, 0);
        chk("rmul_zero", zero, 1);
        reset = 0;
        spur = 0;
        repeat (W + 8) begin
            if (out_valid) spur++;
            tick;
        end
        chk("rmul_no_output", 16'(spur), 0);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            rand_op($urandom_range(0, 7) == 0);
            #1;
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) chk("rnd_spurious_valid", out_valid, 0);
                    else begin
                        chk("rnd_result", alu_result, sb[0].r);
                        chk("rnd_zero", zero, (sb[0].r == 0) ? 16'd1 : 16'd0);
                        chk("rnd_bt", branch_target, sb[0].bt);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                if (in_valid && in_ready) sb.push_back(model_now());
            end
            tick;
        end
        in_valid = 0; flush = 0; out_ready = 1;
        for (int k = 0; k < 3 * W && sb.size() != 0; k++) begin
            if (out_valid) begin
                chk("drain_result", alu_result, sb[0].r);
                chk("drain_bt", branch_target, sb[0].bt);
                void'(sb.pop_front());
            end
            tick;
        end
        chk("drain_empty", 16'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 The block SHALL have parameter WORD, default 64, meaning datapath width in bits (legal: 16 to 64, even).
REQ-002 The block SHALL have parameter BR_SHIFT, default 2, meaning the left shift applied to the immediate for the branch target.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with all state changing only on the rising edge of clk.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  upstream operation present.
REQ-007 in_ready  out  1  block can accept an operation this cycle.
REQ-008 cur_pc  in  WORD  PC of the operation.
REQ-009 read_data1  in  WORD  ALU operand A.
REQ-010 read_data2  in  WORD  register operand B.
REQ-011 sign_extended_output  in  WORD  immediate.
REQ-012 alu_op  in  2  main-control ALU class.
REQ-013 opcode  in  11  instruction opcode [31:21].
REQ-014 alu_src  in  1  1 selects the immediate as operand B, 0 selects read_data2.
REQ-015 flush  in  1  discard all in-flight and held work.
REQ-016 out_valid  out  1  result registers hold a valid result.
REQ-017 out_ready  in  1  downstream accepts the result.
REQ-018 branch_target  out  WORD  registered cur_pc + (imm << BR_SHIFT).
REQ-019 alu_result  out  WORD  registered ALU result.
REQ-020 zero  out  1  registered (alu_result == 0).
REQ-021 busy  out  1  a multiply is in progress.

Function
REQ-022 The ALU control SHALL decode as follows: alu_op 00 -> ADD; alu_op 01 -> PASSB; alu_op 11 -> ADD.
REQ-023 alu_op 10 SHALL decode by opcode: 10001011000 ADD; 11001011000 SUB; 10001010000 AND; 10101010000 ORR; 10011011000 MUL; any other opcode -> ADD.
REQ-024 ADD, SUB, AND, ORR and PASSB SHALL be single-cycle operations, with the result registered on the edge that accepts the input.
REQ-025 Arithmetic SHALL be modulo 2^WORD, with carry and overflow discarded; branch_target SHALL also wrap modulo 2^WORD.
REQ-026 An input SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-027 The state machine SHALL have three states: IDLE, MUL and FULL.
REQ-028 In IDLE, in_ready SHALL be 1.
REQ-029 In IDLE, an accepted single-cycle operation SHALL move the block to FULL.
REQ-030 In IDLE, an accepted MUL SHALL move the block to MUL.
REQ-031 In MUL, the block SHALL run an iterative shift-add multiply at one multiplier bit per cycle, taking WORD cycles, with in_ready 0 and busy 1.
REQ-032 After the final MUL iteration the block SHALL load the low WORD bits of the product into alu_result and go to FULL.
REQ-033 The MUL result SHALL become visible on out_valid exactly WORD+1 edges after acceptance.
REQ-034 In FULL, out_valid SHALL be 1.
REQ-035 In FULL, all outputs SHALL be held stable while out_ready is 0.
REQ-036 In FULL, out_ready=1 SHALL release the result.
REQ-037 in_ready SHALL equal out_ready in FULL, giving single-register pass-through: a simultaneous release and accept keeps the block full of the new single-cycle result, or moves it to MUL for a new MUL.
REQ-038 Steady-state throughput SHALL be one single-cycle operation per clock when out_ready is held at 1.
REQ-039 Operands, alu_src and the decoded operation SHALL be captured at acceptance; later changes on the inputs SHALL NOT affect the operation in flight.
REQ-040 flush SHALL force IDLE, out_valid 0 and busy 0 on the next edge, abort any multiply, and ignore any input offered in that same cycle.
REQ-041 flush SHALL take priority over all other events except reset.
REQ-042 A flush in IDLE SHALL have no effect.

Reset
REQ-043 On reset the block SHALL enter IDLE with out_valid 0, busy 0, alu_result 0, branch_target 0, zero 1 and the multiplier registers 0.
REQ-044 in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after reset deasserts.
REQ-045 Reset asserted mid-multiply or while FULL SHALL discard all work with no output produced.

Verification
REQ-046 Scenario, ADD and branch target: WORD=64, alu_op=10, opcode=10001011000, rd1=5, rd2=7, alu_src=0, pc=0x100, imm=3 -> one cycle later out_valid=1, alu_result=12, zero=0, branch_target=0x10C.
REQ-047 Scenario, SUB to zero with stall: rd1=rd2=0x55, opcode=11001011000, out_ready=0 for 3 cycles -> alu_result=0 and zero=1 held stable with in_ready=0, then released on the first cycle out_ready=1.
REQ-048 Scenario, MUL wrap: WORD=16, rd1=0x0100, rd2=0x0101, MUL -> busy=1 for 16 cycles, out_valid on edge 17, alu_result=0x0100 (low 16 bits of 0x10100).
REQ-049 Scenario, back-to-back: 8 single-cycle operations with in_valid=1 and out_ready=1 -> 8 results on 8 consecutive cycles in order, PASSB (alu_op=01, rd2=0) giving zero=1.
REQ-050 Scenario, flush mid-MUL: flush asserted on MUL cycle 5 together with an offered ADD -> next edge IDLE, busy=0, out_valid=0, ADD not taken; the next ADD completes normally.
REQ-051 Scenario, reset mid-MUL: reset asserted during a MUL -> all outputs at reset values, no spurious out_valid afterwards.
